// File: rtl/cpu_ram_arbiter.sv
// Arbiter that shares a single-port data RAM between the CPU load/store path and a host/debug
// port. The CPU has default priority; a saturating starvation counter forces a host grant after
// STARVE_LIMIT consecutive denied cycles. At most one RAM access is issued per cycle, and
// synchronous read data is routed back to whichever requester issued the read.
// Optional feature: define HOST_LOCK_EN to add a host_lock input and a LOCKED state that keeps
// the RAM with the host while host_req and host_lock stay high.
module cpu_ram_arbiter #(
  parameter int unsigned AW           = 4,
  parameter int unsigned DW           = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  // CPU load/store path
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  // Host/debug port
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
`ifdef HOST_LOCK_EN
  input  logic          host_lock,
`endif
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  // RAM side
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  // Debug
  output logic [3:0]    starve_cnt
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    StCpuPri    = 2'd0,
    StHostForce = 2'd1
`ifdef HOST_LOCK_EN
    ,
    StLocked    = 2'd2
`endif
  } state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnCpu  = 2'd1,
    OwnHost = 2'd2
  } owner_e;

  state_e     state_q, state_d;
  owner_e     rd_owner_q, rd_owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  // Raw arbitration result, independent of reset; drives next-state logic only.
  logic arb_cpu, arb_host;
  // Arbitration result as seen on the ports; forced low while reset is asserted.
  logic cpu_win, host_win;
  logic lock_exit;

  // Select the winner for this cycle from the current priority state.
  always_comb begin
    arb_cpu   = 1'b0;
    arb_host  = 1'b0;
    lock_exit = 1'b0;
    case (state_q)
      StHostForce: begin
        if (host_req) begin
          arb_host = 1'b1;
        end else if (cpu_req) begin
          arb_cpu = 1'b1;
        end
      end
`ifdef HOST_LOCK_EN
      StLocked: begin
        if (host_req && host_lock) begin
          arb_host = 1'b1;
        end else begin
          // Leaving the lock: ownership falls back to normal CPU priority this cycle.
          lock_exit = 1'b1;
          if (cpu_req) begin
            arb_cpu = 1'b1;
          end else if (host_req) begin
            arb_host = 1'b1;
          end
        end
      end
`endif
      default: begin
        if (cpu_req) begin
          arb_cpu = 1'b1;
        end else if (host_req) begin
          arb_host = 1'b1;
        end
      end
    endcase
    cpu_win  = arb_cpu & reset;
    host_win = arb_host & reset;
  end

  // Next-state for the starvation counter, priority state and read-return owner.
  always_comb begin
    starve_cnt_d = 4'd0;
    state_d      = StCpuPri;
    rd_owner_d   = OwnNone;

    if (host_req && !arb_host && !lock_exit) begin
      starve_cnt_d = (starve_cnt_q >= Limit) ? Limit : starve_cnt_q + 4'd1;
    end

`ifdef HOST_LOCK_EN
    // The lock only takes hold once the host has actually won the RAM.
    if (arb_host && host_req && host_lock) begin
      state_d = StLocked;
    end else
`endif
    if (starve_cnt_d == Limit) begin
      state_d = StHostForce;
    end

    if (arb_cpu && !cpu_we) begin
      rd_owner_d = OwnCpu;
    end else if (arb_host && !host_we) begin
      rd_owner_d = OwnHost;
    end
  end

  // State registers; reset also discards any read return in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StCpuPri;
      rd_owner_q   <= OwnNone;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      rd_owner_q   <= rd_owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Drive the RAM from the selected requester and steer read data to the owner.
  always_comb begin
    cpu_gnt   = cpu_win;
    host_gnt  = host_win;
    ram_en    = cpu_win | host_win;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_win) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (host_win) begin
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end

    cpu_rvalid  = (rd_owner_q == OwnCpu);
    host_rvalid = (rd_owner_q == OwnHost);
    cpu_rdata   = cpu_rvalid ? ram_rdata : '0;
    host_rdata  = host_rvalid ? ram_rdata : '0;
    starve_cnt  = starve_cnt_q;
  end

endmodule
